systolic_mmu: RTL and testbench

Parametrised weight-stationary systolic matrix unit: an ARR_SIZE×ARR_SIZE grid of signed multiply-accumulate cells with internally generated input skew and output de-skew. Per-column accumulators reduce results over a tile of activation vectors, and a valid/ready handshake protects both the input and the result. It sits between the activation/weight buffers and the result writeback path, and is the second generation of the array core.

---
 rtl/systolic_mmu.sv | 264 ++++++++++++++++++++++++++
 tb/tb_systolic_mmu.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mmu.sv
// Weight-stationary ARR_SIZE x ARR_SIZE signed MAC array with per-column tile accumulators; SYSTOLIC_SAT_EN selects saturating accumulation.
// Latency: a vector accepted at edge c reaches the accumulators at edge c+2*ARR_SIZE; o_valid rises at c_last+2*ARR_SIZE+1.
// Backpressure: o_ready drops during DRAIN/OUTPUT; the result is held on o_result until o_valid && i_ready.
module systolic_mmu #(
    parameter int ARR_SIZE = 4,
    parameter int DATA_W   = 16,
    parameter int WEIGHT_W = 16,
    parameter int ACC_W    = 40
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic                         i_mode,
    input  logic                         i_last,
    input  logic [ARR_SIZE*WEIGHT_W-1:0] i_weight,
    input  logic [ARR_SIZE*DATA_W-1:0]   i_act,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [ARR_SIZE*ACC_W-1:0]    o_result,
    output logic                         o_err
);

    localparam int N   = ARR_SIZE;
    localparam int PW  = DATA_W + WEIGHT_W;
    localparam int RW  = ($clog2(N) > 2) ? $clog2(N) : 2;
    localparam int VL  = 2 * N;
    localparam int DCW = $clog2(2 * N + 1);

    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, OUTPUT} state_t;

    state_t           state_q, state_d;
    logic [RW-1:0]    row_q, row_d;
    logic [DCW-1:0]   drain_q, drain_d;
    logic             err_q, err_d;
    logic [VL-1:0]    vld_q, vld_d;
    logic             beat, w_wr, act_acc, acc_clr;

    logic signed [WEIGHT_W-1:0] w_q    [N][N];
    logic signed [WEIGHT_W-1:0] w_d    [N][N];
    logic signed [DATA_W-1:0]   in_q   [N];
    logic signed [DATA_W-1:0]   in_d   [N];
    logic signed [DATA_W-1:0]   row_act[N];
    logic signed [DATA_W-1:0]   a_q    [N][N-1];
    logic signed [DATA_W-1:0]   a_d    [N][N-1];
    logic signed [ACC_W-1:0]    psum_q [N][N];
    logic signed [ACC_W-1:0]    psum_d [N][N];
    logic signed [ACC_W-1:0]    col_sum[N];
    logic signed [ACC_W-1:0]    acc_q  [N];
    logic signed [ACC_W-1:0]    acc_d  [N];

    assign o_ready = (state_q == IDLE) || (state_q == LOAD) || (state_q == COMPUTE);
    assign o_valid = (state_q == OUTPUT);
    assign o_err   = err_q;
    assign beat    = i_valid && o_ready;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        drain_d = drain_q;
        err_d   = 1'b0;
        w_wr    = 1'b0;
        act_acc = 1'b0;
        acc_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (beat && !i_mode) begin
                    w_wr    = 1'b1;
                    row_d   = RW'(1);
                    state_d = LOAD;
                end else if (beat) begin
                    act_acc = 1'b1;
                    drain_d = '0;
                    state_d = i_last ? DRAIN : COMPUTE;
                end
            end
            LOAD: begin
                if (beat && !i_mode) begin
                    w_wr = 1'b1;
                    if (row_q == RW'(N - 1)) begin
                        row_d   = '0;
                        state_d = IDLE;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end else if (beat) begin
                    err_d = 1'b1;
                end
            end
            COMPUTE: begin
                if (beat && i_mode) begin
                    act_acc = 1'b1;
                    if (i_last) begin
                        drain_d = '0;
                        state_d = DRAIN;
                    end
                end else if (beat) begin
                    err_d = 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == DCW'(2 * N)) state_d = OUTPUT;
                else                        drain_d = drain_q + DCW'(1);
            end
            OUTPUT: begin
                if (i_ready) begin
                    acc_clr = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        w_d = w_q;
        if (w_wr) begin
            for (int j = 0; j < N; j++) w_d[row_q][j] = i_weight[j*WEIGHT_W +: WEIGHT_W];
        end
        for (int i = 0; i < N; i++) in_d[i] = act_acc ? i_act[i*DATA_W +: DATA_W] : '0;
        vld_d = {vld_q[VL-2:0], act_acc};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            drain_q <= '0;
            err_q   <= 1'b0;
            vld_q   <= '0;
            for (int i = 0; i < N; i++) begin
                in_q[i] <= '0;
                for (int j = 0; j < N; j++) w_q[i][j] <= '0;
            end
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            drain_q <= drain_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            in_q    <= in_d;
            w_q     <= w_d;
        end
    end

    // Input skew: row i sees the vector i cycles after row 0.
    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        if (gi == 0) begin : g_row0
            assign row_act[gi] = in_q[gi];
        end else begin : g_dly
            logic signed [DATA_W-1:0] sk_q [gi];
            logic signed [DATA_W-1:0] sk_d [gi];
            always_comb begin
                sk_d[0] = in_q[gi];
                for (int k = 1; k < gi; k++) sk_d[k] = sk_q[k-1];
            end
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int k = 0; k < gi; k++) sk_q[k] <= '0;
                end else begin
                    sk_q <= sk_d;
                end
            end
            assign row_act[gi] = sk_q[gi-1];
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            logic signed [DATA_W-1:0] a_in;
            logic signed [ACC_W-1:0]  p_in;
            logic        [PW-1:0]     prod;
            if (gj == 0) begin : g_a_edge
                assign a_in = row_act[gi];
            end else begin : g_a_int
                assign a_in = a_q[gi][gj-1];
            end
            if (gi == 0) begin : g_p_edge
                assign p_in = '0;
            end else begin : g_p_int
                assign p_in = psum_q[gi-1][gj];
            end
            assign prod = $signed({{WEIGHT_W{a_in[DATA_W-1]}}, a_in})
                        * $signed({{DATA_W{w_q[gi][gj][WEIGHT_W-1]}}, w_q[gi][gj]});
            assign psum_d[gi][gj] = p_in + {{(ACC_W-PW){prod[PW-1]}}, prod};
            if (gj < N - 1) begin : g_a_fwd
                assign a_d[gi][gj] = a_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) psum_q[i][j] <= '0;
                for (int j = 0; j < N - 1; j++) a_q[i][j] <= '0;
            end
        end else begin
            psum_q <= psum_d;
            a_q    <= a_d;
        end
    end

    // Output de-skew: column j waits N-1-j cycles so all columns land together.
    for (genvar gj = 0; gj < N; gj++) begin : g_deskew
        localparam int D = N - 1 - gj;
        if (D == 0) begin : g_none
            assign col_sum[gj] = psum_q[N-1][gj];
        end else begin : g_dly
            logic signed [ACC_W-1:0] dq_q [D];
            logic signed [ACC_W-1:0] dq_d [D];
            always_comb begin
                dq_d[0] = psum_q[N-1][gj];
                for (int k = 1; k < D; k++) dq_d[k] = dq_q[k-1];
            end
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int k = 0; k < D; k++) dq_q[k] <= '0;
                end else begin
                    dq_q <= dq_d;
                end
            end
            assign col_sum[gj] = dq_q[D-1];
        end
    end

`ifdef SYSTOLIC_SAT_EN
    logic signed [ACC_W:0] sum_x [N];
`endif

    always_comb begin
        for (int j = 0; j < N; j++) begin
`ifdef SYSTOLIC_SAT_EN
            sum_x[j] = {acc_q[j][ACC_W-1], acc_q[j]} + {col_sum[j][ACC_W-1], col_sum[j]};
`endif
            acc_d[j] = acc_q[j];
            if (acc_clr) begin
                acc_d[j] = '0;
            end else if (vld_q[VL-1]) begin
`ifdef SYSTOLIC_SAT_EN
                if (sum_x[j][ACC_W] != sum_x[j][ACC_W-1])
                    acc_d[j] = sum_x[j][ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
                else
                    acc_d[j] = sum_x[j][ACC_W-1:0];
`else
                acc_d[j] = acc_q[j] + col_sum[j];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int j = 0; j < N; j++) acc_q[j] <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    for (genvar gj = 0; gj < N; gj++) begin : g_out
        assign o_result[gj*ACC_W +: ACC_W] = acc_q[gj];
    end

endmodule

// File: tb/tb_systolic_mmu.sv
// Bench for systolic_mmu: table-driven tiles plus hand-written corner sequences, scoreboard queue of tile results.
module tb_systolic_mmu;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int WW = 16;
    localparam int AW = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, i_valid, o_ready, i_mode, i_last, o_valid, i_ready, o_err;
    logic [N*WW-1:0]   i_weight;
    logic [N*DW-1:0]   i_act;
    logic [N*AW-1:0]   o_result;

    logic              s_i_valid, s_o_ready, s_i_mode, s_i_last, s_o_valid, s_i_ready, s_o_err;
    logic [31:0]       s_i_weight, s_i_act;
    logic [71:0]       s_o_result;

    systolic_mmu #(.ARR_SIZE(N), .DATA_W(DW), .WEIGHT_W(WW), .ACC_W(AW)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_mode(i_mode),
        .i_last(i_last), .i_weight(i_weight), .i_act(i_act), .o_valid(o_valid),
        .i_ready(i_ready), .o_result(o_result), .o_err(o_err));

    systolic_mmu #(.ARR_SIZE(4), .DATA_W(8), .WEIGHT_W(8), .ACC_W(18)) dut_sat (
        .clk(clk), .rst(rst), .i_valid(s_i_valid), .o_ready(s_o_ready), .i_mode(s_i_mode),
        .i_last(s_i_last), .i_weight(s_i_weight), .i_act(s_i_act), .o_valid(s_o_valid),
        .i_ready(s_i_ready), .o_result(s_o_result), .o_err(s_o_err));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [3:0][31:0] a;
        logic             last;
        logic [3:0][31:0] e;
    } vec_t;

    vec_t   tbl[7];
    int     w_cur[4][4];
    longint exp_q[$];

    function automatic vec_t mk(int a0, int a1, int a2, int a3, bit last,
                                int e0, int e1, int e2, int e3);
        vec_t v;
        v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
        v.last = last;
        v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
        return v;
    endfunction

    function automatic longint res_col(int j);
        logic signed [AW-1:0] t;
        t = o_result[j*AW +: AW];
        return longint'(t);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_act(input int a0, input int a1, input int a2, input int a3, input bit last);
        i_valid = 1'b1; i_mode = 1'b1; i_last = last;
        i_act = {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
        tick();
        i_valid = 1'b0; i_last = 1'b0;
    endtask

    task automatic send_row(input int k);
        i_valid = 1'b1; i_mode = 1'b0;
        for (int j = 0; j < N; j++) i_weight[j*WW +: WW] = 16'(w_cur[k][j]);
        tick();
        i_valid = 1'b0;
    endtask

    task automatic load_all();
        for (int k = 0; k < N; k++) send_row(k);
    endtask

    task automatic push_exp(input longint e0, input longint e1, input longint e2, input longint e3);
        exp_q.push_back(e0); exp_q.push_back(e1); exp_q.push_back(e2); exp_q.push_back(e3);
    endtask

    task automatic get_result(input string name, input int c_last, input int hold);
        int            waited;
        logic [N*AW-1:0] snap;
        longint        e;
        waited = 0;
        while (!o_valid && waited < 100) begin
            tick();
            waited++;
        end
        check({name, " o_valid seen"}, longint'(o_valid), 1);
        if (!o_valid) begin
            for (int j = 0; j < N; j++) if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        check({name, " latency"}, longint'(cyc - c_last), 2 * N + 1);
        check({name, " o_ready in OUTPUT"}, longint'(o_ready), 0);
        if (hold > 0) begin
            snap = o_result;
            repeat (hold) tick();
            check({name, " result held"}, longint'(o_result == snap), 1);
            check({name, " o_ready held low"}, longint'(o_ready), 0);
            check({name, " o_valid held"}, longint'(o_valid), 1);
        end
        for (int j = 0; j < N; j++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'sd12345678;
            check($sformatf("%s col%0d", name, j), res_col(j), e);
        end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check({name, " o_valid after handshake"}, longint'(o_valid), 0);
        check({name, " o_ready after handshake"}, longint'(o_ready), 1);
    endtask

    initial begin
        int            c;
        int            waited;
        logic signed [17:0] st;
        longint        sat_exp;

        rst = 1'b0; i_valid = 1'b0; i_mode = 1'b0; i_last = 1'b0;
        i_weight = '0; i_act = '0; i_ready = 1'b0;
        s_i_valid = 1'b0; s_i_mode = 1'b0; s_i_last = 1'b0;
        s_i_weight = '0; s_i_act = '0; s_i_ready = 1'b0;

        tbl[0] = mk(1, 2, 3, 4, 1,             13, 2, -3, 6);
        tbl[1] = mk(-5, 7, 0, -1, 1,           -8, 7, 0, -11);
        tbl[2] = mk(32767, -32768, 100, 0, 1,  32767, -32768, -100, 65534);
        tbl[3] = mk(0, 0, 0, 0, 1,             0, 0, 0, 0);
        tbl[4] = mk(1, 1, 1, 1, 0,             0, 0, 0, 0);
        tbl[5] = mk(2, 0, 0, 1, 1,             9, 1, -1, 8);
        tbl[6] = mk(-32768, -32768, -32768, -32768, 1, -131072, -32768, 32768, -98304);

        repeat (3) tick();
        check("reset o_valid", longint'(o_valid), 0);
        check("reset o_ready", longint'(o_ready), 1);
        check("reset o_err", longint'(o_err), 0);
        check("reset o_result", longint'(o_result == '0), 1);
        check("reset sat o_valid", longint'(s_o_valid), 0);
        rst = 1'b1;
        tick();

        // General matrix, table of tiles (vector 4 and 5 form a back-to-back two-vector tile)
        w_cur = '{'{1, 0, 0, 2}, '{0, 1, 0, 0}, '{0, 0, -1, 0}, '{3, 0, 0, 1}};
        load_all();
        for (int t = 0; t < 7; t++) begin
            send_act(int'(tbl[t].a[0]), int'(tbl[t].a[1]), int'(tbl[t].a[2]), int'(tbl[t].a[3]), tbl[t].last);
            if (tbl[t].last) begin
                push_exp(int'(tbl[t].e[0]), int'(tbl[t].e[1]), int'(tbl[t].e[2]), int'(tbl[t].e[3]));
                get_result($sformatf("tbl%0d", t), cyc, 0);
            end
        end

        // Identity
        w_cur = '{'{1, 0, 0, 0}, '{0, 1, 0, 0}, '{0, 0, 1, 0}, '{0, 0, 0, 1}};
        load_all();
        send_act(1, 2, 3, 4, 1);
        push_exp(1, 2, 3, 4);
        get_result("identity", cyc, 0);

        // Bubbles between vectors, then 5 cycles of result backpressure
        w_cur = '{'{2, 2, 2, 2}, '{2, 2, 2, 2}, '{2, 2, 2, 2}, '{2, 2, 2, 2}};
        load_all();
        send_act(1, 1, 1, 1, 0);
        repeat (2) tick();
        send_act(1, 1, 1, 1, 0);
        repeat (2) tick();
        send_act(1, 1, 1, 1, 1);
        push_exp(24, 24, 24, 24);
        get_result("bubble_bp", cyc, 5);
        send_act(1, 0, 0, 0, 1);
        push_exp(2, 2, 2, 2);
        get_result("after_bp", cyc, 0);

        // Illegal activation beat during LOAD
        w_cur = '{'{1, 0, 0, 2}, '{0, 1, 0, 0}, '{0, 0, -1, 0}, '{3, 0, 0, 1}};
        send_row(0);
        send_row(1);
        send_act(9, 9, 9, 9, 0);
        check("err in LOAD pulse", longint'(o_err), 1);
        send_row(2);
        check("err in LOAD clears", longint'(o_err), 0);
        send_row(3);

        // Illegal weight beat during COMPUTE
        send_act(1, 2, 3, 4, 0);
        i_valid = 1'b1; i_mode = 1'b0; i_weight = {4{16'h7777}};
        tick();
        i_valid = 1'b0;
        check("err in COMPUTE pulse", longint'(o_err), 1);
        send_act(-5, 7, 0, -1, 1);
        check("err in COMPUTE clears", longint'(o_err), 0);
        push_exp(5, 9, -3, -5);
        get_result("illegal_w", cyc, 0);

        // Reset in the middle of a tile
        send_act(1, 1, 1, 1, 0);
        send_act(2, 2, 2, 2, 0);
        rst = 1'b0;
        repeat (2) tick();
        check("midrst o_valid", longint'(o_valid), 0);
        check("midrst o_ready", longint'(o_ready), 1);
        check("midrst o_result", longint'(o_result == '0), 1);
        check("midrst o_err", longint'(o_err), 0);
        rst = 1'b1;
        tick();
        send_act(5, 6, 7, 8, 1);
        push_exp(0, 0, 0, 0);
        get_result("post_rst", cyc, 0);

        // Narrow instance: accumulator overflow
`ifdef SYSTOLIC_SAT_EN
        sat_exp = 131071;
`else
        sat_exp = -68596;
`endif
        check("sat o_ready idle", longint'(s_o_ready), 1);
        s_i_mode = 1'b0; s_i_weight = {4{8'd127}};
        for (int k = 0; k < 4; k++) begin
            s_i_valid = 1'b1;
            tick();
        end
        s_i_mode = 1'b1; s_i_act = {4{8'd127}};
        for (int k = 0; k < 3; k++) begin
            s_i_last = (k == 2);
            tick();
        end
        s_i_valid = 1'b0; s_i_last = 1'b0;
        c = cyc;
        waited = 0;
        while (!s_o_valid && waited < 100) begin
            tick();
            waited++;
        end
        check("sat o_valid seen", longint'(s_o_valid), 1);
        check("sat latency", longint'(cyc - c), 9);
        for (int j = 0; j < 4; j++) begin
            st = s_o_result[j*18 +: 18];
            check($sformatf("sat col%0d", j), longint'(st), sat_exp);
        end
        s_i_ready = 1'b1;
        tick();
        s_i_ready = 1'b0;
        check("sat o_valid after handshake", longint'(s_o_valid), 0);
        check("sat o_err", longint'(s_o_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
